// File: rtl/gpu_dispatch_pkg.sv
// gpu_dispatch_pkg: shared state encodings and block-count helper for the kernel dispatcher.
package gpu_dispatch_pkg;
  typedef enum logic [1:0] {RST, RDY, BUSY} core_state_e;
  typedef enum logic [1:0] {K_IDLE, K_RUN, K_DONE} kernel_state_e;
  function automatic logic [7:0] blocks_for(input logic [7:0] thread_count, input int unsigned tpb);
    logic [8:0] s;
    s = {1'b0, thread_count} + 9'(tpb - 1);
    return 8'(s / 9'(tpb));
  endfunction
endpackage

// File: rtl/kernel_dispatch_ctrl_if.sv
// kernel_dispatch_ctrl_if: host and per-core handshake bundle; kernel_cycles exists only with DISPATCH_PERF_EN.
interface kernel_dispatch_ctrl_if #(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4
);
  localparam int TCW = $clog2(THREADS_PER_BLOCK) + 1;
  logic                           start;
  logic                           done;
  logic                           device_control_write_enable;
  logic [7:0]                     device_control_data;
  logic [7:0]                     thread_count;
  logic [NUM_CORES-1:0]           core_done;
  logic [NUM_CORES-1:0]           core_start;
  logic [NUM_CORES-1:0]           core_reset;
  logic [NUM_CORES-1:0][7:0]      core_block_id;
  logic [NUM_CORES-1:0][TCW-1:0]  core_thread_count;
`ifdef DISPATCH_PERF_EN
  logic [31:0]                    kernel_cycles;
`endif
  modport master (
`ifdef DISPATCH_PERF_EN
    input  kernel_cycles,
`endif
    output start, device_control_write_enable, device_control_data, core_done,
    input  done, thread_count, core_start, core_reset, core_block_id, core_thread_count
  );
  modport slave (
`ifdef DISPATCH_PERF_EN
    output kernel_cycles,
`endif
    input  start, device_control_write_enable, device_control_data, core_done,
    output done, thread_count, core_start, core_reset, core_block_id, core_thread_count
  );
endinterface

// File: rtl/device_ctrl_reg.sv
// device_ctrl_reg: 8-bit device control register (kernel thread count), frozen while a kernel runs.
module device_ctrl_reg (
  input  logic       clk,
  input  logic       reset,
  input  logic       we_i,
  input  logic       lock_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);
  logic [7:0] dcr_q;
  always_ff @(posedge clk)
    if (reset) dcr_q <= '0;
    else if (we_i && !lock_i) dcr_q <= data_i;
  assign data_o = dcr_q;
endmodule

// File: rtl/kernel_dispatch_ctrl.sv
// kernel_dispatch_ctrl: splits a kernel into blocks and dispatches them to compute cores.
// Define DISPATCH_PERF_EN to add the kernel_cycles run-length counter.
module kernel_dispatch_ctrl
  import gpu_dispatch_pkg::*;
#(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4
) (
  input logic                   clk,
  input logic                   reset,
  kernel_dispatch_ctrl_if.slave bus
);
  localparam int TCW = $clog2(THREADS_PER_BLOCK) + 1;
  localparam int SH  = $clog2(THREADS_PER_BLOCK);
  kernel_state_e                 k_q, k_d;
  core_state_e                   st_q [NUM_CORES];
  core_state_e                   st_d [NUM_CORES];
  logic [7:0]                    tc, total, rem, disp_q, disp_d, fin_q, fin_d;
  logic [NUM_CORES-1:0][7:0]     bid_q, bid_d;
  logic [NUM_CORES-1:0][TCW-1:0] cnt_q, cnt_d;
  logic [TCW-1:0]                blk_cnt;
  logic [NUM_CORES-1:0]          cs, cr;
  logic                          finish, picked;

  device_ctrl_reg u_dcr (
    .clk    (clk),
    .reset  (reset),
    .we_i   (bus.device_control_write_enable),
    .lock_i (k_q == K_RUN),
    .data_i (bus.device_control_data),
    .data_o (tc)
  );

  assign total   = blocks_for(tc, THREADS_PER_BLOCK);
  assign rem     = tc - (disp_q << SH);
  assign blk_cnt = (rem >= 8'(THREADS_PER_BLOCK)) ? TCW'(THREADS_PER_BLOCK) : rem[TCW-1:0];
  assign finish  = (k_q == K_RUN) && (fin_q == total);

  // Cores are scanned low to high so the lowest-index ready core wins the single dispatch slot.
  always_comb begin
    k_d    = (k_q == K_IDLE && bus.start) ? K_RUN : finish ? K_DONE : k_q;
    st_d   = st_q;
    disp_d = disp_q;
    fin_d  = fin_q;
    bid_d  = bid_q;
    cnt_d  = cnt_q;
    picked = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (k_q != K_RUN || finish) st_d[i] = RST;
      else if (st_q[i] == RST) st_d[i] = RDY;
      else if (st_q[i] == RDY && !picked && disp_q < total) begin
        st_d[i]  = BUSY;
        bid_d[i] = disp_q;
        cnt_d[i] = blk_cnt;
        disp_d   = disp_q + 8'd1;
        picked   = 1'b1;
      end else if (st_q[i] == BUSY && bus.core_done[i]) begin
        st_d[i] = RST;
        fin_d   = fin_d + 8'd1;
      end
    end
  end

  always_ff @(posedge clk)
    if (reset) begin
      k_q    <= K_IDLE;
      st_q   <= '{default: RST};
      disp_q <= '0;
      fin_q  <= '0;
      bid_q  <= '0;
      cnt_q  <= '0;
    end else begin
      k_q    <= k_d;
      st_q   <= st_d;
      disp_q <= disp_d;
      fin_q  <= fin_d;
      bid_q  <= bid_d;
      cnt_q  <= cnt_d;
    end

  always_comb begin
    cs = '0;
    cr = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cs[i] = st_q[i] == BUSY;
      cr[i] = st_q[i] == RST;
    end
  end

  assign bus.core_start        = cs;
  assign bus.core_reset        = cr;
  assign bus.core_block_id     = bid_q;
  assign bus.core_thread_count = cnt_q;
  assign bus.thread_count      = tc;
  assign bus.done              = k_q == K_DONE;

`ifdef DISPATCH_PERF_EN
  logic [31:0] cyc_q;
  always_ff @(posedge clk)
    if (reset || (k_q == K_IDLE && bus.start)) cyc_q <= '0;
    else if (k_q == K_RUN && !(&cyc_q)) cyc_q <= cyc_q + 32'd1;
  assign bus.kernel_cycles = cyc_q;
`endif
endmodule

// File: tb/tb_kernel_dispatch_ctrl.sv
// tb_kernel_dispatch_ctrl: scoreboard bench; expected dispatches queued at launch, checked as cores start.
module tb_kernel_dispatch_ctrl;
  typedef struct {int core; int blk; int cnt;} exp_t;
  logic clk = 1'b0;
  logic reset;
  int   errs = 0, checks = 0, cyc = 0, ndisp = 0, n;
  exp_t sb [$];
  int   lat [2];
  int   rem [2];
  int   dcyc [64];
  logic [1:0] prev, done_drv;

  kernel_dispatch_ctrl_if #(.NUM_CORES(2), .THREADS_PER_BLOCK(4)) bus ();
  kernel_dispatch_ctrl #(.NUM_CORES(2), .THREADS_PER_BLOCK(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (bus.core_start[i] && !prev[i]) begin
        ndisp++;
        dcyc[bus.core_block_id[i][5:0]] = cyc;
        if (sb.size() == 0) chk("spurious_dispatch", 1, 0);
        else begin
          e = sb.pop_front();
          chk("disp_core", i, e.core);
          chk("disp_blk", bus.core_block_id[i], e.blk);
          chk("disp_cnt", bus.core_thread_count[i], e.cnt);
        end
        rem[i] = lat[i];
      end
      if (bus.core_start[i] && rem[i] == 0) done_drv[i] = 1'b1;
      else begin
        done_drv[i] = 1'b0;
        if (rem[i] > 0) rem[i]--;
      end
      prev[i] = bus.core_start[i];
    end
    bus.core_done = done_drv;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.device_control_write_enable = 1'b0;
    bus.device_control_data = '0;
    bus.core_done = '0;
    done_drv = '0;
    prev = '0;
    rem = '{0, 0};
    step();
    step();
    reset = 1'b0;
    sb.delete();
    ndisp = 0;
  endtask

  task automatic push(input int core, input int blk, input int cnt);
    sb.push_back('{core, blk, cnt});
  endtask

  task automatic launch(input int tc);
    bus.device_control_write_enable = 1'b1;
    bus.device_control_data = 8'(tc);
    step();
    bus.device_control_write_enable = 1'b0;
    chk("dcr_load", bus.thread_count, tc);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int cnt);
    cnt = 0;
    while (!bus.done && cnt < 200) begin
      step();
      cnt++;
    end
    chk({tag, "_done"}, bus.done, 1);
    chk({tag, "_core_reset"}, bus.core_reset, 2'b11);
    chk({tag, "_core_start"}, bus.core_start, 0);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    lat = '{0, 0};
    do_reset();
    chk("rst_core_reset", bus.core_reset, 2'b11);
    chk("rst_core_start", bus.core_start, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_thread_count", bus.thread_count, 0);
    chk("rst_block_id", bus.core_block_id, 0);
    chk("rst_tcount", bus.core_thread_count, 0);

    lat = '{2, 2};
    push(0, 0, 4); push(1, 1, 4);
    launch(8);
    wait_done("t2", n);
    bus.start = 1'b1;
    repeat (3) step();
    bus.start = 1'b0;
    chk("t2_restart_ignored", bus.core_start, 0);
    chk("t2_done_sticky", bus.done, 1);

    do_reset();
    lat = '{0, 5};
    push(0, 0, 4); push(1, 1, 4); push(0, 2, 2);
    launch(10);
    wait_done("t3", n);
    chk("t3_ndisp", ndisp, 3);

    do_reset();
    lat = '{0, 0};
    launch(0);
    wait_done("t4", n);
    chk("t4_latency", n, 1);
    step();
    chk("t4_ndisp", ndisp, 0);

    do_reset();
    lat = '{1, 0};
    push(0, 0, 4); push(1, 1, 4); push(0, 2, 4); push(1, 3, 4);
    launch(16);
    wait_done("t5", n);
    chk("t5_blk1_follows_blk0", dcyc[1] - dcyc[0], 1);
    chk("t5_blk3_follows_blk2", dcyc[3] - dcyc[2], 1);

    do_reset();
    lat = '{9, 9};
    push(0, 0, 4); push(1, 1, 4); push(0, 2, 4);
    launch(12);
    repeat (3) step();
    bus.device_control_write_enable = 1'b1;
    bus.device_control_data = 8'd99;
    step();
    bus.device_control_write_enable = 1'b0;
    chk("t6_dcr_locked", bus.thread_count, 12);
    chk("t6_running_busy", bus.core_start, 2'b11);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_core_reset", bus.core_reset, 2'b11);
    chk("t6_core_start", bus.core_start, 0);
    chk("t6_done", bus.done, 0);
    chk("t6_thread_count", bus.thread_count, 0);
    chk("t6_block_id", bus.core_block_id, 0);
    repeat (3) step();
    chk("t6_stays_idle", bus.core_start, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
